// File: rtl/sm4_apb_sequencer.sv
// sm4_apb_sequencer: autonomous APB initiator for the SM4 peripheral.
// Takes one 128-bit command (encrypt / decrypt / key load), issues the
// register sequence over APB, waits for completion and returns the result.
// Optional feature macro: SM4_SEQ_TIMEOUT_EN bounds the interrupt wait
// to TIMEOUT_CYCLES and reports a timeout through rsp_err.
// KEY_WAIT_CYCLES must be at least 2; the post-transfer gap cycle counts as one.
module sm4_apb_sequencer #(
  parameter logic [11:0] BASE_ADDR       = 12'h000,
  parameter int          KEY_WAIT_CYCLES = 20,
  parameter int          TIMEOUT_CYCLES  = 4096
) (
  input  logic         io_mainClk,
  input  logic         resetCtrl_systemReset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [127:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [11:0]  io_apb_PADDR,
  output logic         io_apb_PSEL,
  output logic         io_apb_PENABLE,
  output logic         io_apb_PWRITE,
  output logic [31:0]  io_apb_PWDATA,
  input  logic [31:0]  io_apb_PRDATA,
  input  logic         io_apb_PREADY,
  input  logic         io_apb_PSLVERROR,
  input  logic         io_SM4_interrupt
);

  localparam logic [1:0] OP_ENC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_KEY = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int CNT_MAX = (KEY_WAIT_CYCLES > TIMEOUT_CYCLES) ? KEY_WAIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_WAIT_IRQ, S_KEY_WAIT, S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q;
  logic [127:0]   data_q;
  logic [3:0]     step_q;       // transfer index: 0..5 writes, 6..9 result reads
  logic [CNT_W-1:0] cnt_q;      // cycles spent in the current state
  logic [127:0]   res_q;
  logic           err_q;
  logic           irq_prev_q;
  logic           ready_en_q;   // keeps cmd_ready low until the first edge after reset

  logic           accept;
  logic           xfer_done;
  logic           irq_rise;
  logic           timeout_hit;
  logic [11:0]    seq_off;
  logic           seq_write;
  logic [31:0]    seq_wdata;

  assign accept    = cmd_valid && cmd_ready;
  assign xfer_done = (state_q == S_ACCESS) && io_apb_PREADY;
  assign irq_rise  = io_SM4_interrupt && !irq_prev_q;

`ifdef SM4_SEQ_TIMEOUT_EN
  assign timeout_hit = (state_q == S_WAIT_IRQ) && !irq_rise &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Register map walk: address, direction and write data for the current step.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    seq_off   = 12'h000;
    seq_write = 1'b0;
    seq_wdata = 32'h0;
    case (step_q)
      4'd0: begin
        seq_off   = 12'h14C;
        seq_write = 1'b1;
        seq_wdata = (op_q == OP_ENC) ? 32'd8 : (op_q == OP_DEC) ? 32'd4 : 32'd0;
      end
      4'd1: begin seq_off = (op_q == OP_KEY) ? 12'h138 : 12'h104; seq_write = 1'b1; seq_wdata = data_q[31:0];   end
      4'd2: begin seq_off = (op_q == OP_KEY) ? 12'h13C : 12'h108; seq_write = 1'b1; seq_wdata = data_q[63:32];  end
      4'd3: begin seq_off = (op_q == OP_KEY) ? 12'h140 : 12'h10C; seq_write = 1'b1; seq_wdata = data_q[95:64];  end
      4'd4: begin seq_off = (op_q == OP_KEY) ? 12'h144 : 12'h110; seq_write = 1'b1; seq_wdata = data_q[127:96]; end
      4'd5: begin seq_off = (op_q == OP_KEY) ? 12'h148 : 12'h114; seq_write = 1'b1; seq_wdata = 32'd1;          end
      4'd6: seq_off = 12'h118;
      4'd7: seq_off = 12'h11C;
      4'd8: seq_off = 12'h120;
      4'd9: seq_off = 12'h124;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
    if (resetCtrl_systemReset) state_q <= S_IDLE;
    else                       state_q <= state_d;
  end

  // Next-state logic: APB transfer phases interleaved with the command sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = (cmd_op == OP_RSV) ? S_RESP : S_SETUP;
      S_SETUP:    state_d = S_ACCESS;
      S_ACCESS:   if (io_apb_PREADY) state_d = S_GAP;
      S_GAP: begin
        if (step_q == 4'd5)      state_d = (op_q == OP_KEY) ? S_KEY_WAIT : S_WAIT_IRQ;
        else if (step_q == 4'd9) state_d = S_RESP;
        else                     state_d = S_SETUP;
      end
      S_WAIT_IRQ: begin
        if (irq_rise)         state_d = S_SETUP;
        else if (timeout_hit) state_d = S_RESP;
      end
      S_KEY_WAIT: if (cnt_q == CNT_W'(KEY_WAIT_CYCLES - 2)) state_d = S_RESP;
      S_RESP:     if (rsp_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state; APB address/data are zero while unselected.
  always_comb begin
    cmd_ready      = (state_q == S_IDLE) && ready_en_q;
    io_apb_PSEL    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    io_apb_PENABLE = (state_q == S_ACCESS);
    io_apb_PADDR   = io_apb_PSEL ? (BASE_ADDR + seq_off) : 12'h000;
    io_apb_PWRITE  = io_apb_PSEL && seq_write;
    io_apb_PWDATA  = io_apb_PSEL ? seq_wdata : 32'h0;
    rsp_valid      = (state_q == S_RESP);
    rsp_data       = res_q;
    rsp_err        = err_q;
  end

  // Command capture, step/cycle counters, result and sticky error collection.
  always_ff @(posedge io_mainClk or posedge resetCtrl_systemReset) begin
    if (resetCtrl_systemReset) begin
      op_q       <= OP_ENC;
      data_q     <= '0;
      step_q     <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      irq_prev_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ready_en_q <= 1'b1;
      irq_prev_q <= io_SM4_interrupt;
      cnt_q      <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        step_q <= '0;
        res_q  <= '0;
        err_q  <= (cmd_op == OP_RSV);
      end
      if (state_q == S_GAP) step_q <= step_q + 4'd1;
      if (xfer_done) begin
        if (io_apb_PSLVERROR) err_q <= 1'b1;
        case (step_q)
          4'd6: res_q[127:96] <= io_apb_PRDATA;
          4'd7: res_q[95:64]  <= io_apb_PRDATA;
          4'd8: res_q[63:32]  <= io_apb_PRDATA;
          4'd9: res_q[31:0]   <= io_apb_PRDATA;
          default: ;
        endcase
      end
      if (timeout_hit) err_q <= 1'b1;
    end
  end

endmodule
